// File: rtl/split_com_queue.sv
// rtl/split_com_queue.sv - per-DIMM split-completion FIFO feeding the complete-split arbiter
module split_com_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [11:0]       split_cmd,
    input  logic [7:0]        split_mask,
    input  logic              split_valid,
    output logic              split_ready,
    output logic [19:0]       complete_split_out,
    output logic              pending_complete_split,
    input  logic              read_complete_split,
    output logic [ADDR_W:0]   fifo_count,
    output logic              underflow_sticky,
    input  logic              clear_sticky
);

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

    logic [19:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              rd_q;
    logic [19:0]       out_q;
    logic              sticky_q;

    logic enq;
    logic pop_trig;
    logic pop;
    logic underflow;

    // Ready depends only on registered occupancy, so no input reaches an output combinationally.
    assign split_ready = (count != FULL_COUNT);

    // A zero-mask event completes its handshake but targets no DIMM, so it is dropped.
    assign enq       = split_valid && split_ready && (split_mask != 8'd0);
    assign pop_trig  = read_complete_split && !rd_q;
    assign pop       = pop_trig && (count != '0);
    assign underflow = pop_trig && (count == '0);

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= {split_cmd, split_mask};
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_q     <= 1'b0;
            out_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            rd_q <= read_complete_split;
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                out_q  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // An underflow in the same cycle as a clear keeps the flag set.
            if (underflow) begin
                sticky_q <= 1'b1;
            end else if (clear_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign complete_split_out     = out_q;
    assign pending_complete_split = (count != '0);
    assign fifo_count             = count;
    assign underflow_sticky       = sticky_q;

endmodule
